// File: rtl/temp_pwm_ctrl_multi.sv
// rtl/temp_pwm_ctrl_multi.sv - multi-channel integrating PWM temperature controller
// One shared period counter drives every channel; each channel's duty register integrates once per period.
module temp_pwm_ctrl_multi #(
  parameter int NCH       = 2,
  parameter int TEMP_W    = 8,
  parameter int CNT_W     = 20,
  parameter int GAIN_SH   = 4,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 2**CNT_W - 2,
  parameter int OT_MARGIN = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NCH*TEMP_W-1:0] temp_i,
  input  logic [NCH*3-1:0]      case_i,
  output logic [NCH-1:0]        pwm_o,
  output logic [NCH-1:0]        alarm_o,
  output logic                  period_o
);
  localparam int SW = CNT_W + TEMP_W + 2;
  localparam logic signed [SW-1:0] DMIN_S = SW'(DUTY_MIN);
  localparam logic signed [SW-1:0] DMAX_S = SW'(DUTY_MAX);
  localparam logic [TEMP_W:0]      MARGIN = (TEMP_W+1)'(OT_MARGIN);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  function automatic logic [TEMP_W-1:0] decode_sp(input logic [2:0] code);
    case (code)
      3'd1:    decode_sp = TEMP_W'(40);
      3'd2:    decode_sp = TEMP_W'(70);
      3'd3:    decode_sp = TEMP_W'(100);
      3'd4:    decode_sp = TEMP_W'(127);
      3'd5:    decode_sp = TEMP_W'(150);
      default: decode_sp = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] clamp_duty(input logic signed [SW-1:0] s);
    if (s < DMIN_S)      clamp_duty = DMIN_S[CNT_W-1:0];
    else if (s > DMAX_S) clamp_duty = DMAX_S[CNT_W-1:0];
    else                 clamp_duty = s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign tick     = &cnt;
  assign period_o = tick;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [TEMP_W-1:0]      temp;
    logic [TEMP_W-1:0]      sp;
    logic [2:0]             code;
    logic                   on;
    logic                   alarm;
    logic                   over_temp;
    logic                   cooled;
    logic [CNT_W-1:0]       duty_act;
    logic signed [TEMP_W:0] err;
    logic signed [SW-1:0]   delta;
    logic signed [SW-1:0]   base;
    logic signed [SW-1:0]   sum;

    assign temp      = temp_i[k*TEMP_W +: TEMP_W];
    assign code      = case_i[k*3 +: 3];
    assign on        = (code >= 3'd1) && (code <= 3'd5);
    assign sp        = decode_sp(code);
    assign err       = $signed({1'b0, sp}) - $signed({1'b0, temp});
    assign delta     = SW'(err) <<< GAIN_SH;
    assign over_temp = {1'b0, temp} >= ({1'b0, sp} + MARGIN);
    assign cooled    = temp < sp;
    // Leaving an alarm restarts the integrator from the floor, not from the held duty.
    assign base      = alarm ? DMIN_S : $signed(SW'(duty_act));
    assign sum       = base + delta;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        duty_act <= '0;
        alarm    <= 1'b0;
      end else if (tick) begin
        if (!on) begin
          duty_act <= '0;
          alarm    <= 1'b0;
        end else if (over_temp) begin
          duty_act <= DMIN_S[CNT_W-1:0];
          alarm    <= 1'b1;
        end else if (alarm && cooled) begin
          duty_act <= clamp_duty(sum);
          alarm    <= 1'b0;
        end else if (!alarm) begin
          duty_act <= clamp_duty(sum);
        end
      end
    end

    assign pwm_o[k]   = on & ~alarm & (cnt < duty_act);
    assign alarm_o[k] = alarm;
  end

endmodule

// File: tb/tb_temp_pwm_ctrl_multi.sv
// tb/tb_temp_pwm_ctrl_multi.sv - self-checking bench for temp_pwm_ctrl_multi
// Table rows and directed sequences are measured per period; a cycle-level reference model checks every clock.
module tb_temp_pwm_ctrl_multi;
  localparam int NCH       = 2;
  localparam int TEMP_W    = 8;
  localparam int CNT_W     = 8;
  localparam int GAIN_SH   = 2;
  localparam int DUTY_MIN  = 0;
  localparam int DUTY_MAX  = 250;
  localparam int OT_MARGIN = 10;
  localparam int PERIOD    = 1 << CNT_W;
  localparam int NROWS     = 23;

  logic                  clk_i  = 1'b0;
  logic                  rst_i  = 1'b1;
  logic [NCH*TEMP_W-1:0] temp_i = '0;
  logic [NCH*3-1:0]      case_i = '0;
  logic [NCH-1:0]        pwm_o;
  logic [NCH-1:0]        alarm_o;
  logic                  period_o;

  int checks = 0;
  int errors = 0;

  temp_pwm_ctrl_multi #(
    .NCH(NCH), .TEMP_W(TEMP_W), .CNT_W(CNT_W), .GAIN_SH(GAIN_SH),
    .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX), .OT_MARGIN(OT_MARGIN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .temp_i(temp_i), .case_i(case_i),
    .pwm_o(pwm_o), .alarm_o(alarm_o), .period_o(period_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain integer arithmetic on setpoints, errors and clamps.
  int sp_tab[8] = '{0, 40, 70, 100, 127, 150, 0, 0};
  int m_cnt;
  int m_duty[NCH];
  bit m_alarm[NCH];

  function automatic int ch_sp(int k);
    return sp_tab[case_i[k*3 +: 3]];
  endfunction

  function automatic int ch_temp(int k);
    return int'(temp_i[k*TEMP_W +: TEMP_W]);
  endfunction

  function automatic int clampi(int v);
    if (v < DUTY_MIN) return DUTY_MIN;
    if (v > DUTY_MAX) return DUTY_MAX;
    return v;
  endfunction

  function automatic int next_duty(int duty, bit alarm, int sp, int t);
    if (sp == 0) return 0;
    if (t >= sp + OT_MARGIN) return DUTY_MIN;
    if (alarm && t < sp) return clampi(DUTY_MIN + (sp - t) * (1 << GAIN_SH));
    if (alarm) return duty;
    return clampi(duty + (sp - t) * (1 << GAIN_SH));
  endfunction

  function automatic bit next_alarm(bit alarm, int sp, int t);
    if (sp == 0) return 1'b0;
    if (t >= sp + OT_MARGIN) return 1'b1;
    if (alarm && t < sp) return 1'b0;
    return alarm;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_cnt <= 0;
      for (int k = 0; k < NCH; k++) begin
        m_duty[k]  <= 0;
        m_alarm[k] <= 1'b0;
      end
    end else begin
      if (m_cnt == PERIOD - 1)
        for (int k = 0; k < NCH; k++) begin
          m_duty[k]  <= next_duty(m_duty[k], m_alarm[k], ch_sp(k), ch_temp(k));
          m_alarm[k] <= next_alarm(m_alarm[k], ch_sp(k), ch_temp(k));
        end
      m_cnt <= (m_cnt + 1) % PERIOD;
    end
  end

  logic [NCH-1:0] exp_pwm;
  logic [NCH-1:0] exp_alarm;

  always @(negedge clk_i) begin
    #3;
    for (int k = 0; k < NCH; k++) begin
      exp_pwm[k]   = (ch_sp(k) != 0) && !m_alarm[k] && (m_cnt < m_duty[k]);
      exp_alarm[k] = m_alarm[k];
    end
    checks++;
    if (pwm_o !== exp_pwm || alarm_o !== exp_alarm || period_o !== (m_cnt == PERIOD - 1)) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t pwm=%b alarm=%b period=%b expected pwm=%b alarm=%b period=%b",
               $time, pwm_o, alarm_o, period_o, exp_pwm, exp_alarm, m_cnt == PERIOD - 1);
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic set_ch(int k, int t, int c);
    temp_i[k*TEMP_W +: TEMP_W] = TEMP_W'(t);
    case_i[k*3 +: 3]           = 3'(c);
  endtask

  task automatic wait_period(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_o && n < 2 * PERIOD);
  endtask

  task automatic run_period(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      c0 += int'(pwm_o[0]);
      c1 += int'(pwm_o[1]);
    end
  endtask

  typedef struct {
    int t0; int c0; int t1; int c1;
    int d0; int d1; int al;
  } vec_t;

  vec_t tbl[NROWS];

  initial begin
    int n, c0, c1, t, c;

    tbl[0]  = '{32, 1,  15, 1,  32, 100, 0};
    tbl[1]  = '{32, 1,  50, 1,  64,   0, 2};
    tbl[2]  = '{32, 1,  45, 1,  96,   0, 2};
    tbl[3]  = '{32, 1,  45, 1, 128,   0, 2};
    tbl[4]  = '{32, 1,  39, 1, 160,   4, 0};
    tbl[5]  = '{32, 1,  40, 1, 192,   4, 0};
    tbl[6]  = '{32, 1,  40, 0, 224,   0, 0};
    tbl[7]  = '{32, 1, 200, 0, 250,   0, 0};
    tbl[8]  = '{32, 1, 200, 6, 250,   0, 0};
    tbl[9]  = '{45, 1,   0, 5, 230, 250, 0};
    tbl[10] = '{45, 1, 137, 4, 210,   0, 2};
    tbl[11] = '{45, 1, 126, 4, 190,   4, 0};
    tbl[12] = '{45, 1,  75, 2, 170,   0, 0};
    tbl[13] = '{45, 1,  90, 3, 150,  40, 0};
    tbl[14] = '{45, 1, 255, 5, 130,   0, 2};
    tbl[15] = '{45, 1, 255, 7, 110,   0, 0};
    tbl[16] = '{45, 1, 100, 3,  90,   0, 0};
    tbl[17] = '{45, 1,  99, 3,  70,   4, 0};
    tbl[18] = '{45, 1,  99, 3,  50,   8, 0};
    tbl[19] = '{45, 1,  99, 3,  30,  12, 0};
    tbl[20] = '{45, 1,  99, 3,  10,  16, 0};
    tbl[21] = '{45, 1,  99, 3,   0,  20, 0};
    tbl[22] = '{45, 1,  99, 3,   0,  24, 0};

    #1 rst_i = 1'b0;
    repeat (3) step();
    check("reset_pwm", int'(pwm_o), 0);
    check("reset_alarm", int'(alarm_o), 0);
    check("reset_period", int'(period_o), 0);
    rst_i = 1'b1;
    wait_period(n);
    check("first_period_clock", n, PERIOD - 1);
    wait_period(n);
    check("period_gap", n, PERIOD);

    for (int i = 0; i < NROWS; i++) begin
      set_ch(0, tbl[i].t0, tbl[i].c0);
      set_ch(1, tbl[i].t1, tbl[i].c1);
      run_period(c0, c1);
      check($sformatf("row%0d_duty0", i), c0, tbl[i].d0);
      check($sformatf("row%0d_duty1", i), c1, tbl[i].d1);
      check($sformatf("row%0d_alarm", i), int'(alarm_o), tbl[i].al);
    end

    // Channel switched off mid-period: output drops in the same cycle, duty clears at the tick.
    set_ch(0, 8, 1);
    set_ch(1, 99, 3);
    repeat (21) step();
    check("off_before_pwm", int'(pwm_o), 3);
    case_i[2:0] = 3'd0;
    #1;
    check("off_same_cycle_pwm", int'(pwm_o), 2);
    repeat (PERIOD - 21) step();
    check("off_period_align", int'(period_o), 1);
    run_period(c0, c1);
    check("off_duty0", c0, 0);
    check("off_duty1", c1, 32);

    // Asynchronous reset between clock edges at cnt=77.
    set_ch(0, 8, 1);
    set_ch(1, 60, 1);
    repeat (78) step();
    check("prereset_pwm", int'(pwm_o), 1);
    check("prereset_alarm", int'(alarm_o), 2);
    #1 rst_i = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_o), 0);
    check("async_reset_alarm", int'(alarm_o), 0);
    check("async_reset_period", int'(period_o), 0);
    repeat (2) step();
    set_ch(1, 20, 1);
    rst_i = 1'b1;
    wait_period(n);
    check("rearm_first_period", n, PERIOD - 1);
    run_period(c0, c1);
    check("rebuild_duty0", c0, 128);
    check("rebuild_duty1", c1, 80);
    check("rebuild_alarm", int'(alarm_o), 0);

    // Random periods with occasional mid-period input changes; the cycle model checks every clock.
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < NCH; k++) begin
        c = int'($urandom_range(0, 7));
        t = sp_tab[c] + int'($urandom_range(0, 40)) - 20;
        if (t < 0) t = 0;
        set_ch(k, t, c);
      end
      for (int i = 0; i < PERIOD; i++) begin
        step();
        if ($urandom_range(0, 63) == 0) begin
          c = int'($urandom_range(0, 7));
          set_ch(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 170)), c);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_pwm_ctrl_multi.md
Name: temp_pwm_ctrl_multi

Overview:
Multi-channel closed-loop temperature controller, and the successor to the single-channel PWM heater controller. One shared free-running PWM period counter drives NCH heater outputs. Each channel has its own setpoint code, an integrating duty register with a shift gain and saturation, and an over-temperature alarm. It sits between the sensor readout path (temp_i) and the heater drivers (pwm_o).

Parameters:
NCH, 2, number of channels.
TEMP_W, 8, width of each temperature sample, unsigned, in degrees C.
CNT_W, 20, PWM counter width; period = 2^CNT_W clocks.
GAIN_SH, 4, left shift applied to the error term (integrator gain = 2^GAIN_SH).
DUTY_MIN, 0, lower duty clamp in counts.
DUTY_MAX, 2^CNT_W-2, upper duty clamp in counts; must be greater than or equal to DUTY_MIN.
OT_MARGIN, 10, alarm threshold above the setpoint, in degrees C.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous, active-low reset.
temp_i  in  NCH*TEMP_W  packed temperature samples; channel k = bits [k*TEMP_W +: TEMP_W].
case_i  in  NCH*3  packed setpoint codes; channel k = bits [k*3 +: 3].
pwm_o  out  NCH  heater PWM, one bit per channel.
alarm_o  out  NCH  sticky over-temperature flag per channel.
period_o  out  1  one-cycle pulse while cnt is at its maximum value.

Behaviour:
- Reset (rst_i low, asynchronous): cnt=0, every duty_act=0, every alarm=0. As a result pwm_o=0, alarm_o=0 and period_o=0. Reset mid-period aborts the period. Counting resumes from 0 on the first clock after rst_i is deasserted.
- Counter: cnt increments every clock and wraps from 2^CNT_W-1 to 0. Unlike the old block, it never stalls.
- tick = (cnt == 2^CNT_W-1). period_o = tick, driven combinationally from the register.
- Setpoint decode per channel:
  - Code 1/2/3/4/5 -> 40/70/100/127/150, zero-extended to TEMP_W.
  - Code 0, 6 or 7 -> channel off.
- PWM output: pwm_o[k] = on[k] & ~alarm[k] & (cnt < duty_act[k]). This is combinational from flops plus case_i.
  - duty 0 gives a constant-low output.
  - Code 0 gates the output low immediately (same cycle).
- Update, performed only on the clock edge where tick=1, for each channel k:
  - Off channel: duty_act <= 0, alarm <= 0.
  - Error: e = sp - temp, a signed (TEMP_W+1)-bit value.
  - Delta: delta = e <<< GAIN_SH, sign-extended to CNT_W+TEMP_W+2 bits.
  - Sum: s = duty_act + delta, with no intermediate wrap.
  - Clamp: duty_act <= clamp(s, DUTY_MIN, DUTY_MAX).
  - Alarm set: if temp >= sp + OT_MARGIN (compared at TEMP_W+1 bits), then alarm <= 1 and duty_act <= DUTY_MIN. Set takes priority over the integrator.
  - Alarm clear: if alarm=1 and temp < sp, then alarm <= 0. The integrator resumes from DUTY_MIN on that same tick.
  - Otherwise the alarm holds its value; while it is 1, duty_act is held.
- Sampling: temp_i and case_i are sampled only at tick. Changes between ticks do not affect duty_act; the only exception is the immediate output gating for code 0.
- Duty glitch-freedom: duty_act changes only at wrap, so each period carries exactly one duty value. A new duty takes effect starting at cnt=0 of the next period.
- Channels are fully independent and share only cnt.
- Latency: a temperature change is reflected in duty at the next tick, and in pwm_o from the following cnt=0.

Test Plan:
(Parameters: CNT_W=8, GAIN_SH=2, DUTY_MIN=0, DUTY_MAX=250, OT_MARGIN=10, NCH=2.)
1. Reset and counter: rst_i low for 3 clocks, then high -> pwm_o=00, alarm_o=00. period_o pulses exactly once every 256 clocks, first at clock 255 after release.
2. Ramp and saturation: ch0 code 1, temp 32 -> duty 32, 64, 96, … per period, with pwm high for exactly duty cycles from cnt=0. Duty reaches 250 after period 8 (256 clamps to 250) and stays there.
3. Decrease and floor: ch0 at duty 250, temp 45, sp 40 -> duty 230, 210, … down to 10, then clamps at 0; pwm constant low.
4. Alarm: ch1 code 1, duty 100, temp 50 -> at tick alarm_o[1]=1, pwm_o[1]=0, duty=0. Temp 45 at later ticks -> alarm stays set. Temp 39 -> alarm clears at that tick and duty becomes 4.
5. Channel off mid-period: ch0 duty 128, code set to 0 at cnt=20 -> pwm_o[0]=0 in the same cycle, duty=0 after tick. ch1 is unaffected.
6. Async reset mid-operation: both channels active, rst_i low at cnt=77 between clock edges -> all outputs 0 without a clock edge. After release, duty rebuilds from 0.
